alu_exec: RTL and testbench

// - Execute-stage ALU directly downstream of the ALU control decoder.
// - Consumes the 5-bit alucontrol code plus the two operands and the shift amount, and registers the result into the EX/MEM boundary.
// - Uses a valid/ready handshake with flush support.
// - Optionally holds an iterative radix-2 divider that writes HI/LO.

---
 rtl/alu_exec.sv | 218 +++++++++++++++++++++
 tb/tb_alu_exec.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU feeding the EX/MEM register through a valid/ready handshake.
// Define ALU_EXEC_DIV_EN to include the iterative radix-2 divider that writes HI/LO.
module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alucontrol,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic [4:0]       sa,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   localparam logic [4:0] AND_CONTROL  = 5'd0;
   localparam logic [4:0] OR_CONTROL   = 5'd1;
   localparam logic [4:0] XOR_CONTROL  = 5'd2;
   localparam logic [4:0] NOR_CONTROL  = 5'd3;
   localparam logic [4:0] ADD_CONTROL  = 5'd4;
   localparam logic [4:0] ADDU_CONTROL = 5'd5;
   localparam logic [4:0] SUB_CONTROL  = 5'd6;
   localparam logic [4:0] SUBU_CONTROL = 5'd7;
   localparam logic [4:0] SLT_CONTROL  = 5'd8;
   localparam logic [4:0] SLTU_CONTROL = 5'd9;
   localparam logic [4:0] SLL_CONTROL  = 5'd10;
   localparam logic [4:0] LUI_CONTROL  = 5'd11;

   logic                    vld_p1;
   logic [WIDTH-1:0]        res_p1;
   logic                    ovf_p1;
   logic                    accept;
   logic                    is_div;
   logic                    idle;
   logic                    div_done;
   logic [WIDTH-1:0]        alu_res;
   logic                    alu_ovf;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [WIDTH-1:0]        sum;
   logic [WIDTH-1:0]        diff;

   function automatic logic sgn_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // Signed overflow zeroes the result rather than wrapping.
   function automatic logic [WIDTH-1:0] sat_zero(input logic [WIDTH-1:0] r, input logic ovf);
      return ovf ? '0 : r;
   endfunction

   assign a_s  = srca;
   assign b_s  = srcb;
   assign sum  = srca + srcb;
   assign diff = srca - srcb;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (alucontrol)
         AND_CONTROL:  alu_res = srca & srcb;
         OR_CONTROL:   alu_res = srca | srcb;
         XOR_CONTROL:  alu_res = srca ^ srcb;
         NOR_CONTROL:  alu_res = ~(srca | srcb);
         ADD_CONTROL: begin
            alu_ovf = sgn_ovf(srca[WIDTH-1], srcb[WIDTH-1], sum[WIDTH-1]);
            alu_res = sat_zero(sum, alu_ovf);
         end
         ADDU_CONTROL: alu_res = sum;
         SUB_CONTROL: begin
            alu_ovf = sgn_ovf(srca[WIDTH-1], ~srcb[WIDTH-1], diff[WIDTH-1]);
            alu_res = sat_zero(diff, alu_ovf);
         end
         SUBU_CONTROL: alu_res = diff;
         SLT_CONTROL:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         SLTU_CONTROL: alu_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
         SLL_CONTROL:  alu_res = srcb << sa;
         LUI_CONTROL:  alu_res = srcb << 16;
         default: begin
            alu_res = '0;
            alu_ovf = 1'b0;
         end
      endcase
   end

`ifdef ALU_EXEC_DIV_EN
   localparam logic [4:0] DIV_CONTROL  = 5'd12;
   localparam logic [4:0] DIVU_CONTROL = 5'd13;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             neg_q;
   logic             neg_r;
   logic             dvz;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic [WIDTH-1:0] rem_nx;
   logic             q_bit;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign is_div   = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
   assign idle     = (state == IDLE);
   assign div_done = (state == DONE);
   assign busy     = (state != IDLE);
   assign hi       = hi_r;
   assign lo       = lo_r;

   // Restoring step: quo shifts the dividend out MSB-first while collecting quotient bits.
   assign rem_sh  = {rem, quo[WIDTH-1]};
   assign q_bit   = (rem_sh >= {1'b0, dvs});
   assign rem_sub = rem_sh[WIDTH-1:0] - dvs;
   assign rem_nx  = q_bit ? rem_sub : rem_sh[WIDTH-1:0];
   assign q_fix   = neg_q ? -quo : quo;
   assign r_fix   = neg_r ? -rem : rem;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         hi_r  <= '0;
         lo_r  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dvz   <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (accept && is_div) begin
               state <= RUN;
               cnt   <= '0;
               rem   <= '0;
               dvz   <= (srcb == '0);
               if (alucontrol == DIV_CONTROL) begin
                  quo   <= srca[WIDTH-1] ? -srca : srca;
                  dvs   <= srcb[WIDTH-1] ? -srcb : srcb;
                  neg_q <= srca[WIDTH-1] ^ srcb[WIDTH-1];
                  neg_r <= srca[WIDTH-1];
               end else begin
                  quo   <= srca;
                  dvs   <= srcb;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
               end
            end
            RUN: begin
               quo <= {quo[WIDTH-2:0], q_bit};
               rem <= rem_nx;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= DONE;
            end
            DONE: begin
               hi_r  <= r_fix;
               lo_r  <= dvz ? '1 : q_fix;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign is_div   = 1'b0;
   assign idle     = 1'b1;
   assign div_done = 1'b0;
   assign busy     = 1'b0;
   assign hi       = '0;
   assign lo       = '0;
`endif

   assign in_ready = idle && (!vld_p1 || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   // EX/MEM boundary register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_p1 <= 1'b0;
         res_p1 <= '0;
         ovf_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (accept && !is_div) begin
         vld_p1 <= 1'b1;
         res_p1 <= alu_res;
         ovf_p1 <= alu_ovf;
      end else if (div_done) begin
         vld_p1 <= 1'b1;
         res_p1 <= '0;
         ovf_p1 <= 1'b0;
      end else if (vld_p1 && out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign result    = res_p1;
   assign overflow  = ovf_p1;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against an arithmetic reference model.
// Divider scenarios are compiled in when ALU_EXEC_DIV_EN is defined.
module tb_alu_exec;

   localparam logic [4:0] C_AND   = 5'd0;
   localparam logic [4:0] C_OR    = 5'd1;
   localparam logic [4:0] C_XOR   = 5'd2;
   localparam logic [4:0] C_NOR   = 5'd3;
   localparam logic [4:0] C_ADD   = 5'd4;
   localparam logic [4:0] C_ADDU  = 5'd5;
   localparam logic [4:0] C_SUB   = 5'd6;
   localparam logic [4:0] C_SUBU  = 5'd7;
   localparam logic [4:0] C_SLT   = 5'd8;
   localparam logic [4:0] C_SLTU  = 5'd9;
   localparam logic [4:0] C_SLL   = 5'd10;
   localparam logic [4:0] C_LUI   = 5'd11;
   localparam logic [4:0] C_DIV   = 5'd12;
   localparam logic [4:0] C_DIVU  = 5'd13;
   localparam logic [4:0] C_UNDEF = 5'd31;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alucontrol;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [4:0]  sa;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   alu_exec #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .sa(sa), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow(overflow), .hi(hi), .lo(lo), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          ntests = 0;
   int          nfail = 0;
   int          n_xfer_model = 0;
   int          n_xfer_dut = 0;
   logic        mvld;
   logic [31:0] mres;
   logic        movf;
   logic [31:0] mhi;
   logic [31:0] mlo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0b want %0b", tag, obs, exp);
      end
   endtask

   // Returns {overflow, result} from the arithmetic meaning of each opcode.
   function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
      longint      x, y, t, lim;
      logic [63:0] u;
      x   = $signed(a);
      y   = $signed(b);
      lim = 2147483647;
      case (op)
         C_AND:  return {1'b0, a & b};
         C_OR:   return {1'b0, a | b};
         C_XOR:  return {1'b0, a ^ b};
         C_NOR:  return {1'b0, ~(a | b)};
         C_ADD, C_SUB: begin
            t = (op == C_ADD) ? x + y : x - y;
            if (t > lim || t < -lim - 1) return {1'b1, 32'd0};
            return {1'b0, t[31:0]};
         end
         C_ADDU: begin u = {32'd0, a} + {32'd0, b}; return {1'b0, u[31:0]}; end
         C_SUBU: begin u = {32'd0, a} - {32'd0, b}; return {1'b0, u[31:0]}; end
         C_SLT:  return {1'b0, (x < y) ? 32'd1 : 32'd0};
         C_SLTU: begin
            t = a;
            lim = b;
            return {1'b0, (t < lim) ? 32'd1 : 32'd0};
         end
         C_SLL: begin
            u = {32'd0, b};
            for (int i = 0; i < int'(s); i++) u = u * 2;
            return {1'b0, u[31:0]};
         end
         C_LUI:  return {1'b0, b[15:0], 16'h0000};
         default: return 33'd0;
      endcase
   endfunction

   // Returns {hi, lo} for a divide.
   function automatic logic [63:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == C_DIVU) begin
         x = a;
         y = b;
      end else begin
         x = $signed(a);
         y = $signed(b);
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [4:0] rnd_op();
      case ($urandom_range(0, 14))
         0: return C_AND;   1: return C_OR;    2: return C_XOR;  3: return C_NOR;
         4: return C_ADD;   5: return C_ADDU;  6: return C_SUB;  7: return C_SUBU;
         8: return C_SLT;   9: return C_SLTU;  10: return C_SLL; 11: return C_LUI;
`ifdef ALU_EXEC_DIV_EN
         12: return C_UNDEF;
         13: return 5'd20;
`else
         12: return C_DIV;
         13: return C_DIVU;
`endif
         default: return C_UNDEF;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s, input logic ordy,
                        input logic fl);
      in_valid   = v;
      alucontrol = op;
      srca       = a;
      srcb       = b;
      sa         = s;
      out_ready  = ordy;
      flush      = fl;
   endtask

   // One clock of single-cycle traffic; entered and left 1 time unit after a rising edge.
   task automatic step();
      logic        er;
      logic        acc;
      logic [32:0] r;
      #1;
      er = (!mvld || out_ready) && !flush;
      chk1("in_ready", in_ready, er);
      acc = in_valid && er;
      r = ref_alu(alucontrol, srca, srcb, sa);
      if (mvld && out_ready && !flush) n_xfer_model++;
      if (out_valid && out_ready && !flush) n_xfer_dut++;
      @(posedge clk);
      #1;
      if (flush) mvld = 1'b0;
      else if (acc) begin
         mvld = 1'b1;
         {movf, mres} = r;
      end else if (mvld && out_ready) mvld = 1'b0;
      chk1("out_valid", out_valid, mvld);
      if (mvld) begin
         chk("result", result, mres);
         chk1("overflow", overflow, movf);
      end
      chk("hi", hi, mhi);
      chk("lo", lo, mlo);
      chk1("busy", busy, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_result"}, result, 32'd0);
      chk1({tag, "_overflow"}, overflow, 1'b0);
      chk({tag, "_hi"}, hi, 32'd0);
      chk({tag, "_lo"}, lo, 32'd0);
      chk1({tag, "_busy"}, busy, 1'b0);
   endtask

`ifdef ALU_EXEC_DIV_EN
   task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int          lat;
      int          nbusy;
      logic [63:0] e;
      drive(1'b1, op, a, b, 5'd0, 1'b1, 1'b0);
      #1;
      chk1("div_accept_ready", in_ready, 1'b1);
      e = ref_div(op, a, b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mvld = 1'b0;
      lat = 1;
      nbusy = 0;
      while (!out_valid && lat < 40) begin
         if (busy) nbusy++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("div_latency", lat, 34);
      chk("div_busy_cycles", nbusy, 33);
      chk1("div_out_valid", out_valid, 1'b1);
      chk("div_result", result, 32'd0);
      chk1("div_overflow", overflow, 1'b0);
      chk("div_lo", lo, e[31:0]);
      chk("div_hi", hi, e[63:32]);
      mhi = e[63:32];
      mlo = e[31:0];
      mvld = 1'b1;
      mres = 32'd0;
      movf = 1'b0;
      step();
   endtask
`endif

   initial begin
      int seen;
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      resetn = 1'b0;
      mvld = 1'b0; mres = 32'd0; movf = 1'b0; mhi = 32'd0; mlo = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      resetn = 1'b1;

      drive(1'b1, C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0); step();
      chk1("add_ovf_flag", overflow, 1'b1);
      chk("add_ovf_res", result, 32'd0);
      drive(1'b1, C_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0); step();
      chk("addu_res", result, 32'h8000_0000);
      chk1("addu_ovf", overflow, 1'b0);
      drive(1'b1, C_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0); step();
      chk("slt_res", result, 32'd1);
      drive(1'b1, C_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0); step();
      chk("sltu_res", result, 32'd0);
      drive(1'b1, C_SLL, 32'h0, 32'h1, 5'd31, 1'b1, 1'b0); step();
      chk("sll_res", result, 32'h8000_0000);
      drive(1'b1, C_LUI, 32'h0, 32'h1234, 5'd0, 1'b1, 1'b0); step();
      chk("lui_res", result, 32'h1234_0000);
      drive(1'b1, C_SUB, 32'h8000_0000, 32'h1, 5'd0, 1'b1, 1'b0); step();
      chk1("sub_ovf_flag", overflow, 1'b1);
      drive(1'b1, C_UNDEF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b1, 1'b0); step();
      chk("undef_res", result, 32'd0);
      chk1("undef_valid", out_valid, 1'b1);
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0); step();

      // Output stall: three blocked cycles, then full-rate draining.
      drive(1'b1, C_OR, 32'hF0F0_0000, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0); step();
      drive(1'b1, C_XOR, 32'hFFFF_0000, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_result", result, 32'hF0F0_ABCD);
      end
      out_ready = 1'b1; step();
      chk("drain_xor", result, 32'hEDCB_5678);
      drive(1'b1, C_NOR, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0); step();
      chk("drain_nor", result, 32'hFFFF_FFFF);
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0); step();

      // Flush kills a held result and refuses the offered op.
      drive(1'b1, C_ADDU, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0); step();
      drive(1'b1, C_ADDU, 32'd7, 32'd8, 5'd0, 1'b0, 1'b1); step();
      chk1("flush_kill", out_valid, 1'b0);
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0); step();

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, rnd_op(), rnd_val(), rnd_val(),
               5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
         step();
      end
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      step();
      step();
      chk("xfer_count", n_xfer_dut, n_xfer_model);

`ifdef ALU_EXEC_DIV_EN
      do_div(C_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
      chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
      do_div(C_DIVU, 32'd100, 32'd7);
      chk("divu_100_7_lo", lo, 32'd14);
      chk("divu_100_7_hi", hi, 32'd2);
      do_div(C_DIVU, 32'd5, 32'd0);
      chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
      chk("divu_by0_hi", hi, 32'd5);
      do_div(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_minneg_lo", lo, 32'h8000_0000);
      chk("div_minneg_hi", hi, 32'd0);
      do_div(C_DIV, 32'hFFFF_FFF0, 32'd0);
      for (int i = 0; i < 6; i++)
         do_div(($urandom_range(0, 1) != 0) ? C_DIV : C_DIVU, rnd_val(), rnd_val());

      // Flush during RUN cycle 10 abandons the divide.
      drive(1'b1, C_DIVU, 32'd1000, 32'd3, 5'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 1; k < 10; k++) begin
         chk1("flush_div_busy", busy, 1'b1);
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      #1;
      chk1("flush_div_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk1("flush_div_busy_after", busy, 1'b0);
      chk1("flush_div_valid", out_valid, 1'b0);
      chk1("flush_div_ready_after", in_ready, 1'b1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("flush_div_no_result", seen, 0);
      chk("flush_div_hi", hi, mhi);
      chk("flush_div_lo", lo, mlo);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a divide.
      drive(1'b1, C_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check_all_zero("rst_mid_div");
      mvld = 1'b0; mhi = 32'd0; mlo = 32'd0;
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      do_div(C_DIV, 32'h1234_5678, 32'hFFFF_FF00);
`endif

      // Asynchronous reset while a result is held.
      drive(1'b1, C_OR, 32'hA5A5_A5A5, 32'h1, 5'd0, 1'b0, 1'b0); step();
      chk1("rst_hold_valid_before", out_valid, 1'b1);
      in_valid = 1'b0;
      #3;
      resetn = 1'b0;
      #1;
      check_all_zero("rst_held");
      mvld = 1'b0; mhi = 32'd0; mlo = 32'd0;
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, C_SUB, 32'd10, 32'd3, 5'd0, 1'b1, 1'b0); step();
      chk("post_reset_sub", result, 32'd7);
      drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0); step();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
